// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core/debug) arbiter in front of a single-ported
// data memory. Grants are combinational in the request cycle. The memory
// command is registered one cycle later, and read data is routed back to
// the owning port two cycles after the grant.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    // Core port
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,

    // Debug port
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,

    // Memory port
    output logic              o_wr,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wr_data,
    input  logic [DATA_W-1:0] i_rd_data
);

    localparam int unsigned CNT_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

    // Owner of the command currently presented on the memory port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DBG  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_consec;
    logic                w_consec_full;
    logic                w_sel_dbg;
    logic                w_c_gnt;
    logic                w_d_gnt;

    logic                r_wr;
    logic                r_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                w_wr_nxt;
    logic                w_rd_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wr_data_nxt;

    logic                r_c_rvalid;
    logic                r_d_rvalid;
    logic                w_c_rvalid_nxt;
    logic                w_d_rvalid_nxt;

    // Arbitration: core wins ties until it has starved debug for MAX_CONSEC grants
    always_comb begin
        w_consec_full = (r_consec == CNT_MAX);
        w_sel_dbg     = i_d_req & (~i_c_req | w_consec_full);
        w_d_gnt       = i_rst_n & w_sel_dbg;
        w_c_gnt       = i_rst_n & i_c_req & ~w_sel_dbg;
    end

    // Starvation counter: counts core wins while debug is waiting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_consec <= '0;
        end else if (!i_d_req || w_d_gnt) begin
            r_consec <= '0;
        end else if (w_c_gnt && !w_consec_full) begin
            r_consec <= r_consec + CNT_W'(1);
        end
    end

    // Owner FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next owner, next memory command, and read-return routing from the current owner
    always_comb begin
        w_state_nxt    = ST_IDLE;
        w_wr_nxt       = 1'b0;
        w_rd_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_wr_data_nxt  = r_wr_data;
        w_c_rvalid_nxt = (r_state == ST_CORE) & r_rd;
        w_d_rvalid_nxt = (r_state == ST_DBG)  & r_rd;

        if (w_c_gnt) begin
            w_state_nxt   = ST_CORE;
            w_wr_nxt      = i_c_we;
            w_rd_nxt      = ~i_c_we;
            w_addr_nxt    = i_c_addr;
            w_wr_data_nxt = i_c_wdata;
        end else if (w_d_gnt) begin
            w_state_nxt   = ST_DBG;
            w_wr_nxt      = i_d_we;
            w_rd_nxt      = ~i_d_we;
            w_addr_nxt    = i_d_addr;
            w_wr_data_nxt = i_d_wdata;
        end
    end

    // Registered memory command; address and write data hold when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr      <= w_wr_nxt;
            r_rd      <= w_rd_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Second pipeline stage: read-valid per port, aligned with memory read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_c_rvalid <= w_c_rvalid_nxt;
            r_d_rvalid <= w_d_rvalid_nxt;
        end
    end

    // Output drive; read data is steered to the owning port and zeroed otherwise
    always_comb begin
        o_c_gnt    = w_c_gnt;
        o_d_gnt    = w_d_gnt;
        o_wr       = r_wr;
        o_rd       = r_rd;
        o_addr     = r_addr;
        o_wr_data  = r_wr_data;
        o_c_rvalid = r_c_rvalid;
        o_d_rvalid = r_d_rvalid;
        o_c_rdata  = r_c_rvalid ? i_rd_data : '0;
        o_d_rdata  = r_d_rvalid ? i_rd_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned MC = 4;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    int n_checks;
    int n_fail;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CONSEC(MC)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_c_req    (c_req),
        .i_c_we     (c_we),
        .i_c_addr   (c_addr),
        .i_c_wdata  (c_wdata),
        .o_c_gnt    (c_gnt),
        .o_c_rvalid (c_rvalid),
        .o_c_rdata  (c_rdata),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_d_gnt    (d_gnt),
        .o_d_rvalid (d_rvalid),
        .o_d_rdata  (d_rdata),
        .o_wr       (wr),
        .o_rd       (rd),
        .o_addr     (addr),
        .o_wr_data  (wr_data),
        .i_rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        c_req = 1'b1; d_req = 1'b1;
        rd_data = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        n_checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: c_gnt=%b d_gnt=%b expected 0/0", c_gnt, d_gnt); end
        n_checks++; if (wr !== 1'b0 || rd !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: wr=%b rd=%b expected 0/0", wr, rd); end
        n_checks++; if (addr !== '0 || wr_data !== '0) begin n_fail++; $display("FAIL reset_bus: addr=%h wr_data=%h expected 0/0", addr, wr_data); end
        n_checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: c=%b d=%b expected 0/0", c_rvalid, d_rvalid); end
        n_checks++; if (c_rdata !== '0 || d_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: c=%h d=%h expected 0/0", c_rdata, d_rdata); end
        // First cycle out of reset can be granted
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        c_req = 1'b1; c_addr = 9'd77;
        #1;
        n_checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL first_grant: c_gnt=%b d_gnt=%b expected 1/0", c_gnt, d_gnt); end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (rd !== 1'b1 || wr !== 1'b0 || addr !== 9'd77) begin n_fail++; $display("FAIL first_cmd: rd=%b wr=%b addr=%0d expected 1/0/77", rd, wr, addr); end
        idle_cycles(3);
    endtask

    task automatic test_core_read();
        @(negedge clk);
        drive_idle();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'd12;
        #1;
        n_checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL core_read_gnt: c_gnt=%b d_gnt=%b expected 1/0", c_gnt, d_gnt); end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (rd !== 1'b1 || wr !== 1'b0 || addr !== 9'd12) begin n_fail++; $display("FAIL core_read_cmd: rd=%b wr=%b addr=%0d expected 1/0/12", rd, wr, addr); end
        @(negedge clk);
        rd_data = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL core_read_ret: c_rvalid=%b c_rdata=%h expected 1/deadbeef", c_rvalid, c_rdata); end
        n_checks++; if (d_rvalid !== 1'b0 || d_rdata !== '0) begin n_fail++; $display("FAIL core_read_other: d_rvalid=%b d_rdata=%h expected 0/0", d_rvalid, d_rdata); end
        n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL core_read_idle: rd=%b expected 0", rd); end
        @(negedge clk); #1;
        n_checks++; if (c_rvalid !== 1'b0 || c_rdata !== '0) begin n_fail++; $display("FAIL core_read_pulse: c_rvalid=%b c_rdata=%h expected 0/0", c_rvalid, c_rdata); end
        idle_cycles(2);
    endtask

    task automatic test_debug_write();
        @(negedge clk);
        drive_idle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'd300; d_wdata = 32'h0000_00FF;
        #1;
        n_checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin n_fail++; $display("FAIL dbg_write_gnt: d_gnt=%b c_gnt=%b expected 1/0", d_gnt, c_gnt); end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (wr !== 1'b1 || rd !== 1'b0 || addr !== 9'd300 || wr_data !== 32'hFF) begin n_fail++; $display("FAIL dbg_write_cmd: wr=%b rd=%b addr=%0d wdata=%h expected 1/0/300/ff", wr, rd, addr, wr_data); end
        @(negedge clk);
        rd_data = 32'h1234_5678;
        #1;
        n_checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg_write_norv: c=%b d=%b expected 0/0", c_rvalid, d_rvalid); end
        n_checks++; if (wr !== 1'b0 || addr !== 9'd300 || wr_data !== 32'hFF) begin n_fail++; $display("FAIL dbg_write_hold: wr=%b addr=%0d wdata=%h expected 0/300/ff", wr, addr, wr_data); end
        idle_cycles(2);
    endtask

    task automatic test_fairness();
        logic exp_d;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b0; c_addr = AW'(i);
            d_req = 1'b1; d_we = 1'b0; d_addr = AW'(100 + i);
            #1;
            exp_d = ((i % 5) == 4);
            n_checks++; if (c_gnt !== ~exp_d || d_gnt !== exp_d) begin n_fail++; $display("FAIL fairness[%0d]: c_gnt=%b d_gnt=%b expected %b/%b", i, c_gnt, d_gnt, ~exp_d, exp_d); end
        end
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_idle();
            if (k == 0 || k == 2) begin c_req = 1'b1; c_addr = AW'(k + 1); end
            if (k == 1) begin d_req = 1'b1; d_addr = 9'd2; end
            rd_data = (k >= 2) ? DW'((k - 1) * 32'h10) : '0;
            #1;
            if (k <= 2) begin
                n_checks++; if (c_gnt !== (k != 1) || d_gnt !== (k == 1)) begin n_fail++; $display("FAIL b2b_gnt[%0d]: c_gnt=%b d_gnt=%b", k, c_gnt, d_gnt); end
            end
            if (k >= 1 && k <= 3) begin
                n_checks++; if (rd !== 1'b1 || addr !== AW'(k)) begin n_fail++; $display("FAIL b2b_cmd[%0d]: rd=%b addr=%0d expected 1/%0d", k, rd, addr, k); end
            end
            if (k >= 2) begin
                n_checks++;
                if (c_rvalid !== (k != 3) || d_rvalid !== (k == 3) ||
                    ((k != 3) && c_rdata !== DW'((k - 1) * 32'h10)) ||
                    ((k == 3) && d_rdata !== 32'h20)) begin
                    n_fail++;
                    $display("FAIL b2b_ret[%0d]: c_rv=%b c_rd=%h d_rv=%b d_rd=%h expected data %h", k, c_rvalid, c_rdata, d_rvalid, d_rdata, (k - 1) * 32'h10);
                end
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_idle();
        c_req = 1'b1; c_addr = 9'd5;
        #1;
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: c_gnt=%b expected 1", c_gnt); end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        n_checks++; if (rd !== 1'b0 || c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: rd=%b c_rvalid=%b expected 0/0", rd, c_rvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        rd_data = 32'h0BAD_0BAD;
        #1;
        n_checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || c_rdata !== '0) begin n_fail++; $display("FAIL rmid_stale1: c_rv=%b d_rv=%b c_rd=%h expected 0/0/0", c_rvalid, d_rvalid, c_rdata); end
        @(negedge clk); #1;
        n_checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || rd !== 1'b0) begin n_fail++; $display("FAIL rmid_stale2: c_rv=%b d_rv=%b rd=%b expected 0/0/0", c_rvalid, d_rvalid, rd); end
        @(negedge clk);
        c_req = 1'b1; c_addr = 9'd7;
        #1;
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_regnt: c_gnt=%b expected 1", c_gnt); end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (rd !== 1'b1 || addr !== 9'd7) begin n_fail++; $display("FAIL rmid_recmd: rd=%b addr=%0d expected 1/7", rd, addr); end
        @(negedge clk);
        rd_data = 32'hCAFE_0007;
        #1;
        n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hCAFE_0007) begin n_fail++; $display("FAIL rmid_reret: c_rv=%b c_rd=%h expected 1/cafe0007", c_rvalid, c_rdata); end
        idle_cycles(2);
    endtask

    task automatic test_idle_gap();
        logic exp_d;
        @(negedge clk);
        drive_idle();
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'd50; c_wdata = 32'hA5A5_0050;
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (wr !== 1'b1 || rd !== 1'b0 || addr !== 9'd50) begin n_fail++; $display("FAIL idle_wr: wr=%b rd=%b addr=%0d expected 1/0/50", wr, rd, addr); end
        @(negedge clk); #1;
        n_checks++; if (wr !== 1'b0 || rd !== 1'b0 || addr !== 9'd50) begin n_fail++; $display("FAIL idle_gap: wr=%b rd=%b addr=%0d expected 0/0/50", wr, rd, addr); end
        // Two core wins with debug waiting, then debug drops: count must restart
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        end
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c_req = 1'b1; d_req = 1'b1;
            #1;
            exp_d = (i == 4);
            n_checks++; if (c_gnt !== ~exp_d || d_gnt !== exp_d) begin n_fail++; $display("FAIL consec_clear[%0d]: c_gnt=%b d_gnt=%b expected %b/%b", i, c_gnt, d_gnt, ~exp_d, exp_d); end
        end
        idle_cycles(3);
    endtask

    // Randomized traffic checked against a transaction-level model
    task automatic test_random();
        int          consec;
        bit          c_pend, d_pend;
        bit          p1_v, p1_we, p1_dbg;
        bit          p2_rd, p2_dbg;
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_wdata;
        bit          e_cg, e_dg, e_wr, e_rd, e_crv, e_drv;
        logic [DW-1:0] e_crd, e_drd;
        consec = 0; c_pend = 0; d_pend = 0;
        p1_v = 0; p1_we = 0; p1_dbg = 0; p2_rd = 0; p2_dbg = 0;
        last_addr = addr; last_wdata = wr_data;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 59) != 0);
            if (c_pend && $urandom_range(0, 19) == 0) begin c_req = 1'b0; c_pend = 0; end
            else if (!c_pend) begin
                c_req = ($urandom_range(0, 9) < 6); c_we = 1'($urandom);
                c_addr = AW'($urandom); c_wdata = $urandom; c_pend = c_req;
            end
            if (d_pend && $urandom_range(0, 19) == 0) begin d_req = 1'b0; d_pend = 0; end
            else if (!d_pend) begin
                d_req = ($urandom_range(0, 9) < 5); d_we = 1'($urandom);
                d_addr = AW'($urandom); d_wdata = $urandom; d_pend = d_req;
            end
            rd_data = $urandom;
            #1;
            if (!rst_n) begin
                consec = 0; p1_v = 0; p2_rd = 0; last_addr = '0; last_wdata = '0;
                e_cg = 0; e_dg = 0;
            end else begin
                e_dg = d_req && (!c_req || consec == int'(MC));
                e_cg = c_req && !e_dg;
            end
            e_wr  = p1_v && p1_we;
            e_rd  = p1_v && !p1_we;
            e_crv = p2_rd && !p2_dbg;
            e_drv = p2_rd && p2_dbg;
            e_crd = e_crv ? rd_data : '0;
            e_drd = e_drv ? rd_data : '0;
            n_checks++; if (c_gnt !== e_cg || d_gnt !== e_dg) begin n_fail++; $display("FAIL rnd_gnt@%0d: c=%b d=%b expected %b/%b", cyc, c_gnt, d_gnt, e_cg, e_dg); end
            n_checks++; if (wr !== e_wr || rd !== e_rd) begin n_fail++; $display("FAIL rnd_strobe@%0d: wr=%b rd=%b expected %b/%b", cyc, wr, rd, e_wr, e_rd); end
            n_checks++; if (addr !== last_addr || wr_data !== last_wdata) begin n_fail++; $display("FAIL rnd_bus@%0d: addr=%h wdata=%h expected %h/%h", cyc, addr, wr_data, last_addr, last_wdata); end
            n_checks++; if (c_rvalid !== e_crv || c_rdata !== e_crd) begin n_fail++; $display("FAIL rnd_cret@%0d: rv=%b rd=%h expected %b/%h", cyc, c_rvalid, c_rdata, e_crv, e_crd); end
            n_checks++; if (d_rvalid !== e_drv || d_rdata !== e_drd) begin n_fail++; $display("FAIL rnd_dret@%0d: rv=%b rd=%h expected %b/%h", cyc, d_rvalid, d_rdata, e_drv, e_drd); end
            if (rst_n) begin
                p2_rd  = p1_v && !p1_we;
                p2_dbg = p1_dbg;
                p1_v   = e_cg || e_dg;
                p1_dbg = e_dg;
                p1_we  = e_dg ? d_we : c_we;
                if (e_cg) begin last_addr = c_addr; last_wdata = c_wdata; c_pend = 0; end
                if (e_dg) begin last_addr = d_addr; last_wdata = d_wdata; d_pend = 0; end
                if (!d_req || e_dg) consec = 0;
                else if (e_cg && consec < int'(MC)) consec = consec + 1;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        idle_cycles(3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rd_data  = '0;
        drive_idle();
        test_reset();
        test_core_read();
        test_debug_write();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        test_idle_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_CONSEC, default 4, max consecutive core grants while debug waits.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 c_req / c_we  input  1 / 1  core request; write when c_we=1, read otherwise.
REQ-007 c_addr / c_wdata  input  ADDR_W / DATA_W  core address / write data.
REQ-008 c_gnt  output  1  core request accepted this cycle.
REQ-009 c_rvalid / c_rdata  output  1 / DATA_W  core read data valid / value.
REQ-010 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: debug port, identical widths and meanings to the core port.
REQ-011 wr / rd  output  1 / 1  memory write / read strobe, registered.
REQ-012 addr / wr_data  output  ADDR_W / DATA_W  memory address / write data, registered.
REQ-013 rd_data  input  DATA_W  memory read data, valid the cycle after rd.

Function
REQ-014 Grant is combinational within cycle N: x_gnt=1 only when x_req=1 and x is selected; at most one gnt per cycle.
REQ-015 Selection, cycle N: only one requester -> that one; both -> core, unless consec==MAX_CONSEC, then debug.
REQ-016 consec (width clog2(MAX_CONSEC+1)): +1 on a core grant with d_req=1, saturating at MAX_CONSEC; cleared on a debug grant or whenever d_req=0.
REQ-017 Granted request drives wr/rd/addr/wr_data in cycle N+1 (one cycle latency); wr=c_we|d_we of winner, rd=its complement; wr and rd never both 1.
REQ-018 No grant in cycle N -> wr=0, rd=0 in cycle N+1; addr/wr_data hold last value.
REQ-019 Owner FSM: states IDLE, CORE, DBG = owner of the command on the memory port; next state = CORE on core grant, DBG on debug grant, else IDLE.
REQ-020 Read granted in cycle N: owner's x_rvalid=1 and x_rdata=rd_data in cycle N+2, one-cycle pulse; other port rvalid=0.
REQ-021 x_rdata is 0 whenever x_rvalid=0.
REQ-022 Writes produce no rvalid.
REQ-023 Back-to-back grants every cycle allowed, including alternating owners; read-data routing tracks each read independently (pipelined owner register).
REQ-024 Requester holds req, we, addr, wdata stable until gnt; arbiter samples them only in the grant cycle.
REQ-025 Request withdrawn before grant: no command, no state change besides consec rule.

Reset
REQ-026 reset=0 asynchronously forces: FSM=IDLE, consec=0, wr=0, rd=0, addr=0, wr_data=0, c_rvalid=d_rvalid=0, rdata=0; gnt outputs 0 while reset=0.
REQ-027 Reset mid-operation discards in-flight commands and pending read returns; no rvalid issued for them after release.
REQ-028 First grant possible in first cycle with reset=1.

Verification
REQ-029 Core read only: c_req=1,c_we=0,c_addr=9'd12, rd_data=32'hDEADBEEF at N+2 -> c_gnt@N, rd=1,addr=12@N+1, c_rvalid=1,c_rdata=32'hDEADBEEF@N+2, d_rvalid=0.
REQ-030 Debug write: d_req=1,d_we=1,d_addr=9'd300,d_wdata=32'h0000_00FF -> d_gnt@N, wr=1,addr=300,wr_data=32'hFF@N+1, no rvalid.
REQ-031 Both requesting continuously, MAX_CONSEC=4 -> grant pattern C,C,C,C,D,C,C,C,C,D...
REQ-032 Alternating reads core addr 1, debug addr 2, core addr 3 on consecutive cycles, rd_data=addr*0x10 -> c_rvalid data 0x10, d_rvalid data 0x20, c_rvalid data 0x30 on consecutive cycles, each to correct port.
REQ-033 Assert reset=0 cycle after a core read grant -> rd, c_rvalid stay 0; after release, no stale rvalid; next request served normally.
REQ-034 Idle cycle between requests -> wr=rd=0 that cycle, FSM IDLE, consec cleared when d_req=0.
